// File: rtl/alu_if.sv
// Command/response bundle between a command issuer and alu_seq_param.
interface alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [2*WIDTH-1:0]   result;

    modport master (output start, output op, output a, output b,
                    input busy, input done, input err, input result);
    modport slave  (input start, input op, input a, input b,
                    output busy, output done, output err, output result);
endinterface

// File: rtl/alu_seq_param.sv
// Parametrised ALU: single-cycle logic/arith ops, multi-cycle shift-add multiply,
// start/done handshake with registered result and error flag.
module alu_seq_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   result_q, result_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [RW-1:0]   acc_sum_c;

    // One shift-add step: accumulate the shifted multiplicand when the multiplier LSB is set
    assign acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = err_q;
        busy_d   = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL) begin
                        mcand_d  = RW'(bus.a);
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b0;
                        case (bus.op)
                            OP_NOP: result_d = result_q;
                            OP_ADD: result_d = RW'(bus.a) + RW'(bus.b);
                            OP_AND: result_d = RW'(bus.a & bus.b);
                            OP_XOR: result_d = RW'(bus.a ^ bus.b);
                            OP_SUB: result_d = RW'(bus.a) - RW'(bus.b);
                            OP_OR:  result_d = RW'(bus.a | bus.b);
                            default: err_d   = 1'b1;
                        endcase
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_sum_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Last step: the accumulator including this step's add is the product
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = acc_sum_c;
                    done_d   = 1'b1;
                    err_d    = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_alu_seq_param.sv
// Randomised + directed bench for alu_seq_param at WIDTH=8 and WIDTH=4 side by side.
module tb_alu_seq_param;
    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] exp8   = 0;
    logic [31:0] exp4   = 0;
    logic        experr = 1'b0;

    alu_if #(.WIDTH(8)) bus8 ();
    alu_if #(.WIDTH(4)) bus4 ();

    assign bus8.start = start;
    assign bus8.op    = op;
    assign bus8.a     = a;
    assign bus8.b     = b;
    assign bus4.start = start;
    assign bus4.op    = op;
    assign bus4.a     = a[3:0];
    assign bus4.b     = b[3:0];

    alu_seq_param #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    alu_seq_param #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: spec arithmetic on wide integers, masked to 2*w bits
    function automatic logic [31:0] ref_res(input int w, input logic [2:0] o,
                                            input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] prev);
        longint unsigned mask = (64'd1 << (2 * w)) - 64'd1;
        longint unsigned xm = 64'(x) & ((64'd1 << w) - 64'd1);
        longint unsigned ym = 64'(y) & ((64'd1 << w) - 64'd1);
        longint unsigned r;
        case (o)
            3'd1: r = xm + ym;
            3'd2: r = xm & ym;
            3'd3: r = xm ^ ym;
            3'd4: r = xm * ym;
            3'd5: r = xm - ym;
            3'd6: r = xm | ym;
            default: r = 64'(prev);
        endcase
        return 32'(r & mask);
    endfunction

    task automatic check_both(input string tag, input logic d8, input logic d4,
                              input logic bz8, input logic bz4,
                              input logic [31:0] r8, input logic [31:0] r4,
                              input logic e8, input logic e4);
        check_eq({tag, "_done8"}, 32'(bus8.done), 32'(d8));
        check_eq({tag, "_done4"}, 32'(bus4.done), 32'(d4));
        check_eq({tag, "_busy8"}, 32'(bus8.busy), 32'(bz8));
        check_eq({tag, "_busy4"}, 32'(bus4.busy), 32'(bz4));
        check_eq({tag, "_res8"},  32'(bus8.result), r8);
        check_eq({tag, "_res4"},  32'(bus4.result), r4);
        check_eq({tag, "_err8"},  32'(bus8.err), 32'(e8));
        check_eq({tag, "_err4"},  32'(bus4.err), 32'(e4));
    endtask

    // Called at a negedge; issues one single-cycle op and checks the done cycle
    task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        exp8   = ref_res(8, o, 32'(x), 32'(y), exp8);
        exp4   = ref_res(4, o, 32'(x), 32'(y), exp4);
        experr = (o == 3'd7);
        check_both("op", 1'b1, 1'b1, 1'b0, 1'b0, exp8, exp4, experr, experr);
    endtask

    // Called at a negedge; multiplies, optionally spamming start while both units are busy,
    // optionally asserting reset during cycle index abort_at (0 = first cycle after start edge)
    task automatic do_mul(input logic [7:0] x, input logic [7:0] y, input bit junk, input int abort_at);
        logic [31:0] p8 = ref_res(8, 3'd4, 32'(x), 32'(y), 0);
        logic [31:0] p4 = ref_res(4, 3'd4, 32'(x), 32'(y), 0);
        start = 1'b1; op = 3'd4; a = x; b = y;
        @(posedge clk);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (abort_at >= 0 && c == abort_at + 1) begin
                reset  = 1'b0;
                exp8   = 0;
                exp4   = 0;
                experr = 1'b0;
                check_both("abort", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
                return;
            end
            check_both("mul", c == 8, c == 4, c < 8, c < 4,
                       (c >= 8) ? p8 : exp8, (c >= 4) ? p4 : exp4,
                       (c >= 8) ? 1'b0 : experr, (c >= 4) ? 1'b0 : experr);
            if (junk && c <= 2) begin
                start = 1'b1; op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            if (abort_at >= 0 && c == abort_at) reset = 1'b1;
        end
        exp8   = p8;
        exp4   = p4;
        experr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_both("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

        do_op(3'd1, 8'd200, 8'd100);
        do_op(3'd5, 8'd5, 8'd7);
        do_mul(8'd255, 8'd255, 1'b1, -1);
        do_op(3'd1, 8'd3, 8'd4);
        do_op(3'd7, 8'd1, 8'd2);
        do_op(3'd2, 8'hF0, 8'h3C);
        do_mul(8'd12, 8'd10, 1'b0, 2);
        do_mul(8'd12, 8'd10, 1'b0, -1);
        do_mul(8'd15, 8'd15, 1'b0, -1);
        do_op(3'd1, 8'd15, 8'd15);
        do_op(3'd6, 8'h09, 8'h06);
        do_op(3'd1, 8'd200, 8'd100);
        do_op(3'd0, 8'd1, 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_both("idle", 1'b0, 1'b0, 1'b0, 1'b0, exp8, exp4, experr, experr);
        end

        for (int i = 0; i < 200; i++) begin
            logic [2:0] o = 3'($urandom_range(0, 7));
            logic [7:0] x = 8'($urandom);
            logic [7:0] y = 8'($urandom);
            if (o == 3'd4) do_mul(x, y, 1'($urandom_range(0, 1)), -1);
            else           do_op(o, x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
